uart_rx: RTL and testbench

//   UART receiver: 8N1-style serial-to-parallel, driven by the 16x-oversampling baud tick
//   (b_tick) from the baud tick generator. Synchronises rx, detects and validates a start
//   bit, samples each bit at mid-point (tick 8 of 16), checks the stop bit and presents
//   one byte per frame to the downstream RX FIFO / command decoder as a 1-clk strobe.

---
 rtl/uart_rx.sv | 127 ++++++++++++
 tb/tb_uart_rx.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receiver, 8N1-style, driven by a 16x oversampling baud tick.
// Samples each bit at its midpoint and emits one-clock done / framing-error strobes.
module uart_rx #(
    parameter int DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 b_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 rx_busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e               state_q;
    logic                 rx_meta_q, rx_s_q;
    logic [3:0]           tick_q;
    logic [3:0]           tick_d;
    logic [2:0]           bit_q;
    logic [DATA_BITS-1:0] shreg_q, data_q;
    logic                 done_q, ferr_q, busy_q;

    assign tick_d    = tick_q + 4'd1;
    assign rx_data   = data_q;
    assign rx_done   = done_q;
    assign frame_err = ferr_q;
    assign rx_busy   = busy_q;

    // Sync flops reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            ferr_q <= 1'b0;
            if (b_tick) begin
                case (state_q)
                    S_IDLE: begin
                        if (!rx_s_q) begin
                            state_q <= S_START;
                            tick_q  <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_START: begin
                        if (tick_q == 4'd7) begin
                            tick_q <= '0;
                            if (!rx_s_q) begin
                                state_q <= S_DATA;
                                bit_q   <= '0;
                            end else begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    S_DATA: begin
                        if (tick_q == 4'd15) begin
                            tick_q  <= '0;
                            shreg_q <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
                            if (bit_q == 3'(DATA_BITS - 1)) state_q <= S_STOP;
                            else                            bit_q   <= bit_q + 3'd1;
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    S_STOP: begin
                        // Leaving at mid stop bit leaves half a bit to catch a back-to-back start.
                        if (tick_q == 4'd15) begin
                            tick_q <= '0;
                            busy_q <= 1'b0;
                            if (rx_s_q) begin
                                data_q  <= shreg_q;
                                done_q  <= 1'b1;
                                state_q <= S_IDLE;
                            end else begin
                                ferr_q  <= 1'b1;
                                state_q <= S_BREAK;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    S_BREAK: begin
                        if (rx_s_q) begin
                            state_q <= S_IDLE;
                            tick_q  <= '0;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a serial line driver plus a frame-level reference model
// (expected byte / framing-error events) compared against the observed strobes.
module tb_uart_rx;
    localparam int DIV = 6;
    localparam int BIT = 16 * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       b_tick = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_done, frame_err, rx_busy;

    int         vectors = 0;
    int         miscompares = 0;
    bit         tick_stuck = 1'b0;
    logic [7:0] last_good = 8'h00;

    // Observed events: kind 0 = good byte, 1 = framing error, 2 = both strobes at once.
    int         obs_kind[$];
    logic [7:0] obs_data[$];
    logic       obs_busy[$];
    logic       obs_prev_busy[$];
    logic       prev_busy = 1'b0;

    uart_rx #(.DATA_BITS(8)) dut (
        .clk(clk), .rst_n(rst_n), .b_tick(b_tick), .rx(rx),
        .rx_data(rx_data), .rx_done(rx_done), .frame_err(frame_err), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int div_cnt;
        div_cnt = 0;
        forever begin
            @(negedge clk);
            b_tick  = tick_stuck || (div_cnt == DIV - 1);
            div_cnt = (div_cnt + 1) % DIV;
        end
    end

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rx_done || frame_err) begin
                obs_kind.push_back((rx_done && frame_err) ? 2 : (rx_done ? 0 : 1));
                obs_data.push_back(rx_data);
                obs_busy.push_back(rx_busy);
                obs_prev_busy.push_back(prev_busy);
            end
            prev_busy = rx_busy;
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_obs();
        obs_kind.delete();
        obs_data.delete();
        obs_busy.delete();
        obs_prev_busy.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int bp);
        rx = 1'b0;
        wait_clk(bp);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            wait_clk(bp);
        end
        rx = stop;
        wait_clk(bp);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clk(3);
        vectors++;
        if ({rx_data, rx_done, frame_err, rx_busy} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got data=%h done=%b ferr=%b busy=%b want all 0",
                     rx_data, rx_done, frame_err, rx_busy);
        end
        rst_n = 1'b1;
        wait_clk(2 * BIT);
        vectors++;
        if (obs_kind.size() != 0 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_idle: got events=%0d busy=%b want 0 and 0", obs_kind.size(), rx_busy);
        end
    endtask

    task automatic test_basic();
        clear_obs();
        send_frame(8'hA5, 1'b1, BIT);
        wait_clk(2 * BIT);
        vectors++;
        if (obs_kind.size() != 1) begin
            miscompares++;
            $display("FAIL basic_count: got %0d events want 1", obs_kind.size());
        end else begin
            vectors++;
            if (obs_kind[0] != 0 || obs_data[0] !== 8'hA5) begin
                miscompares++;
                $display("FAIL basic_event: got kind=%0d data=%h want kind=0 data=a5", obs_kind[0], obs_data[0]);
            end
            vectors++;
            if (obs_busy[0] !== 1'b0 || obs_prev_busy[0] !== 1'b1) begin
                miscompares++;
                $display("FAIL basic_busy_fall: got busy=%b prev=%b want 0 prev 1", obs_busy[0], obs_prev_busy[0]);
            end
        end
        last_good = 8'hA5;
        vectors++;
        if (rx_data !== last_good) begin
            miscompares++;
            $display("FAIL basic_hold: got %h want %h", rx_data, last_good);
        end
    endtask

    task automatic test_glitch();
        clear_obs();
        rx = 1'b0;
        wait_clk(3 * DIV);
        vectors++;
        if (rx_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL glitch_busy_rise: got %b want 1", rx_busy);
        end
        rx = 1'b1;
        wait_clk(12 * DIV);
        vectors++;
        if (rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch_busy_fall: got %b want 0", rx_busy);
        end
        wait_clk(BIT);
        vectors++;
        if (obs_kind.size() != 0 || rx_data !== last_good) begin
            miscompares++;
            $display("FAIL glitch_reject: got events=%0d data=%h want 0 events data=%h",
                     obs_kind.size(), rx_data, last_good);
        end
    endtask

    task automatic test_frame_err();
        clear_obs();
        send_frame(8'h3C, 1'b0, BIT);
        rx = 1'b0;
        wait_clk(20 * BIT);
        vectors++;
        if (obs_kind.size() != 1 || (obs_kind.size() == 1 && obs_kind[0] != 1)) begin
            miscompares++;
            $display("FAIL ferr_single: got %0d events (first kind %0d) want one frame_err",
                     obs_kind.size(), (obs_kind.size() > 0) ? obs_kind[0] : -1);
        end
        vectors++;
        if (rx_data !== last_good || rx_done !== 1'b0 || rx_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ferr_state: got data=%h done=%b busy=%b want data=%h done=0 busy=0",
                     rx_data, rx_done, rx_busy, last_good);
        end
        rx = 1'b1;
        wait_clk(2 * BIT);
        clear_obs();
        send_frame(8'h55, 1'b1, BIT);
        wait_clk(2 * BIT);
        vectors++;
        if (obs_kind.size() != 1 || (obs_kind.size() == 1 && (obs_kind[0] != 0 || obs_data[0] !== 8'h55))) begin
            miscompares++;
            $display("FAIL ferr_recover: got %0d events data=%h want one byte 55", obs_kind.size(), rx_data);
        end
        last_good = 8'h55;
    endtask

    task automatic test_back_to_back();
        clear_obs();
        send_frame(8'h00, 1'b1, BIT);
        send_frame(8'hFF, 1'b1, BIT);
        wait_clk(2 * BIT);
        vectors++;
        if (obs_kind.size() != 2) begin
            miscompares++;
            $display("FAIL b2b_count: got %0d events want 2", obs_kind.size());
        end else begin
            vectors++;
            if (obs_kind[0] != 0 || obs_kind[1] != 0 || obs_data[0] !== 8'h00 || obs_data[1] !== 8'hFF) begin
                miscompares++;
                $display("FAIL b2b_data: got kinds %0d,%0d data %h,%h want 0,0 00,ff",
                         obs_kind[0], obs_kind[1], obs_data[0], obs_data[1]);
            end
        end
        last_good = 8'hFF;
    endtask

    task automatic test_mid_reset();
        logic [7:0] d;
        d = 8'h81;
        rx = 1'b0;
        wait_clk(BIT);
        for (int i = 0; i < 4; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        rx = d[4];
        wait_clk(BIT / 2);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({rx_data, rx_done, frame_err, rx_busy} !== 11'd0) begin
            miscompares++;
            $display("FAIL midreset_async: got data=%h done=%b ferr=%b busy=%b want all 0",
                     rx_data, rx_done, frame_err, rx_busy);
        end
        wait_clk(10);
        rst_n = 1'b1;
        wait_clk(BIT - BIT / 2 - 10);
        for (int i = 5; i < 8; i++) begin
            rx = d[i];
            wait_clk(BIT);
        end
        rx = 1'b1;
        wait_clk(12 * BIT);
        clear_obs();
        send_frame(8'h81, 1'b1, BIT);
        wait_clk(2 * BIT);
        vectors++;
        if (obs_kind.size() != 1 || (obs_kind.size() == 1 && (obs_kind[0] != 0 || obs_data[0] !== 8'h81))
            || rx_data !== 8'h81) begin
            miscompares++;
            $display("FAIL midreset_resend: got %0d events data=%h want one byte 81", obs_kind.size(), rx_data);
        end
        last_good = 8'h81;
    endtask

    task automatic test_baud_tolerance();
        int bps[2];
        bps[0] = (BIT * 103 + 50) / 100;
        bps[1] = (BIT * 97 + 50) / 100;
        for (int k = 0; k < 2; k++) begin
            clear_obs();
            send_frame(8'hC3, 1'b1, bps[k]);
            wait_clk(2 * BIT);
            vectors++;
            if (obs_kind.size() != 1 || (obs_kind.size() == 1 && (obs_kind[0] != 0 || obs_data[0] !== 8'hC3))) begin
                miscompares++;
                $display("FAIL baud_tol_%0d: got %0d events data=%h want one byte c3 at bit=%0d clk",
                         k, obs_kind.size(), rx_data, bps[k]);
            end
        end
        last_good = 8'hC3;
    endtask

    task automatic test_random();
        int         exp_kind[$];
        logic [7:0] exp_data[$];
        logic [7:0] d;
        logic       stop;
        int         gap;
        clear_obs();
        for (int n = 0; n < 16; n++) begin
            d    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            gap  = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            send_frame(d, stop, BIT);
            wait_clk(gap * BIT);
            exp_kind.push_back(stop ? 0 : 1);
            exp_data.push_back(stop ? d : last_good);
            if (stop) last_good = d;
        end
        wait_clk(2 * BIT);
        vectors++;
        if (obs_kind.size() != exp_kind.size()) begin
            miscompares++;
            $display("FAIL random_count: got %0d events want %0d", obs_kind.size(), exp_kind.size());
        end else begin
            for (int i = 0; i < exp_kind.size(); i++) begin
                vectors++;
                if (obs_kind[i] != exp_kind[i] || obs_data[i] !== exp_data[i]) begin
                    miscompares++;
                    $display("FAIL random_frame_%0d: got kind=%0d data=%h want kind=%0d data=%h",
                             i, obs_kind[i], obs_data[i], exp_kind[i], exp_data[i]);
                end
            end
        end
        vectors++;
        if (rx_data !== last_good) begin
            miscompares++;
            $display("FAIL random_hold: got %h want %h", rx_data, last_good);
        end
    endtask

    task automatic test_stuck_tick();
        logic [7:0] d;
        d = 8'($urandom);
        tick_stuck = 1'b1;
        clear_obs();
        wait_clk(4);
        send_frame(d, 1'b1, 16);
        wait_clk(32);
        tick_stuck = 1'b0;
        vectors++;
        if (obs_kind.size() != 1 || (obs_kind.size() == 1 && (obs_kind[0] != 0 || obs_data[0] !== d))) begin
            miscompares++;
            $display("FAIL stuck_tick: got %0d events data=%h want one byte %h", obs_kind.size(), rx_data, d);
        end
        last_good = d;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_mid_reset();
        test_baud_tolerance();
        test_random();
        test_stuck_tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
